// File: rtl/eq_spi_bank.sv
// SPI mode-0 slave that loads NUM_BANDS equalizer coefficients and commits them atomically.
// SPI pins are oversampled in the clk domain; the old coefficient set is shifted out on sdo during each frame.
module eq_spi_bank #(
    parameter int NUM_BANDS   = 4,
    parameter int COEF_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter logic [NUM_BANDS*COEF_W-1:0] COEF_RESET = '0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        sck,
    input  logic                        sdi,
    input  logic                        load,
    output logic                        sdo,
    output logic [NUM_BANDS*COEF_W-1:0] coeffs,
    output logic                        done,
    output logic                        frame_err,
    output logic                        busy
);

    localparam int FRAME_W = NUM_BANDS * COEF_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1) + 1;
    localparam int NSIG    = 3;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [NSIG-1:0] raw_in;
    logic [NSIG-1:0] synced;
    logic            sck_s, sdi_s, load_s;
    logic            sck_d_reg, load_d_reg;
    logic            sck_rise, sck_fall, load_rise, load_fall;

    logic [FRAME_W-1:0] shreg_reg,  shreg_next;
    logic [CNT_W-1:0]   cnt_reg,    cnt_next;
    logic               sdo_reg,    sdo_next;
    logic [FRAME_W-1:0] coeffs_reg, coeffs_next;
    logic               done_reg,   done_next;
    logic               ferr_reg,   ferr_next;

    assign raw_in = {load, sdi, sck};

    // One independent synchronizer chain per asynchronous SPI pin.
    generate
        for (genvar gi = 0; gi < NSIG; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    chain_reg <= '0;
                end else begin
                    chain_reg <= {chain_reg[SYNC_STAGES-2:0], raw_in[gi]};
                end
            end

            assign synced[gi] = chain_reg[SYNC_STAGES-1];
        end
    endgenerate

    assign sck_s  = synced[0];
    assign sdi_s  = synced[1];
    assign load_s = synced[2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_d_reg  <= 1'b0;
            load_d_reg <= 1'b0;
        end else begin
            sck_d_reg  <= sck_s;
            load_d_reg <= load_s;
        end
    end

    assign sck_rise  = sck_s & ~sck_d_reg;
    assign sck_fall  = ~sck_s & sck_d_reg;
    assign load_rise = load_s & ~load_d_reg;
    assign load_fall = ~load_s & load_d_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            shreg_reg  <= '0;
            cnt_reg    <= '0;
            sdo_reg    <= 1'b0;
            coeffs_reg <= COEF_RESET;
            done_reg   <= 1'b0;
            ferr_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            shreg_reg  <= shreg_next;
            cnt_reg    <= cnt_next;
            sdo_reg    <= sdo_next;
            coeffs_reg <= coeffs_next;
            done_reg   <= done_next;
            ferr_reg   <= ferr_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        shreg_next  = shreg_reg;
        cnt_next    = cnt_reg;
        sdo_next    = sdo_reg;
        coeffs_next = coeffs_reg;
        done_next   = 1'b0;
        ferr_next   = ferr_reg;

        case (state_reg)
            IDLE: begin
                if (load_rise) begin
                    state_next = SHIFT;
                    shreg_next = coeffs_reg;
                    cnt_next   = '0;
                    sdo_next   = coeffs_reg[FRAME_W-1];
                end
            end
            SHIFT: begin
                // load fall wins over a coincident sck edge so the bit count is final.
                if (load_fall) begin
                    state_next = COMMIT;
                end else if (sck_rise) begin
                    shreg_next = {shreg_reg[FRAME_W-2:0], sdi_s};
                    if (cnt_reg != CNT_SAT) begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end else if (sck_fall) begin
                    sdo_next = shreg_reg[FRAME_W-1];
                end
            end
            COMMIT: begin
                state_next = IDLE;
                if (cnt_reg == CNT_FULL) begin
                    coeffs_next = shreg_reg;
                    done_next   = 1'b1;
                    ferr_next   = 1'b0;
                end else begin
                    ferr_next   = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign sdo       = sdo_reg;
    assign coeffs    = coeffs_reg;
    assign done      = done_reg;
    assign frame_err = ferr_reg;
    assign busy      = (state_reg == SHIFT);

endmodule

// File: tb/tb_eq_spi_bank.sv
// Bench for eq_spi_bank: a 4x8 instance and an 8x12 instance share clk/reset; sel routes the SPI pins.
// Expected coefficients and readback words go into queues as frames are driven and are popped on commit.
module tb_eq_spi_bank;

    localparam int S = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic sck = 1'b0;
    logic sdi = 1'b0;
    logic load = 1'b0;
    logic sel = 1'b0;

    logic        sck_a, sdi_a, load_a, sdo_a, done_a, ferr_a, busy_a;
    logic [31:0] coeffs_a;
    logic        sck_b, sdi_b, load_b, sdo_b, done_b, ferr_b, busy_b;
    logic [95:0] coeffs_b;

    logic         sdo_v, done_v, ferr_v;
    logic [127:0] coeffs_v;

    int checks = 0;
    int failures = 0;

    logic [127:0] exp_coef_q[$];
    logic [127:0] exp_rd_q[$];
    logic [127:0] model_coef = '0;
    logic         model_sdo = 1'b0;

    always #5 clk = ~clk;

    assign sck_a  = sel ? 1'b0 : sck;
    assign sdi_a  = sel ? 1'b0 : sdi;
    assign load_a = sel ? 1'b0 : load;
    assign sck_b  = sel ? sck  : 1'b0;
    assign sdi_b  = sel ? sdi  : 1'b0;
    assign load_b = sel ? load : 1'b0;

    assign sdo_v    = sel ? sdo_b  : sdo_a;
    assign done_v   = sel ? done_b : done_a;
    assign ferr_v   = sel ? ferr_b : ferr_a;
    assign coeffs_v = sel ? {32'b0, coeffs_b} : {96'b0, coeffs_a};

    eq_spi_bank #(.NUM_BANDS(4), .COEF_W(8), .SYNC_STAGES(S)) u_dut (
        .clk(clk), .reset_n(reset_n), .sck(sck_a), .sdi(sdi_a), .load(load_a),
        .sdo(sdo_a), .coeffs(coeffs_a), .done(done_a), .frame_err(ferr_a), .busy(busy_a)
    );

    eq_spi_bank #(.NUM_BANDS(8), .COEF_W(12), .SYNC_STAGES(S)) u_dut_wide (
        .clk(clk), .reset_n(reset_n), .sck(sck_b), .sdi(sdi_b), .load(load_b),
        .sdo(sdo_b), .coeffs(coeffs_b), .done(done_b), .frame_err(ferr_b), .busy(busy_b)
    );

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_frame();
        load = 1'b1;
        wait_clks(6);
    endtask

    // Shifts nbits MSB-first (bits past fw are zero) and captures sdo just before each sck rise.
    task automatic send_bits(input int nbits, input logic [127:0] data, input int fw,
                             output logic [127:0] rd);
        rd = '0;
        for (int i = 0; i < nbits; i++) begin
            int idx;
            idx = fw - 1 - i;
            sdi = (idx >= 0) ? data[idx] : 1'b0;
            wait_clks(3);
            rd = {rd[126:0], sdo_v};
            sck = 1'b1;
            wait_clks(6);
            sck = 1'b0;
            wait_clks(3);
        end
        wait_clks(3);
    endtask

    // Drops load and watches done for a bounded window; lat counts clk edges from the load fall.
    task automatic end_frame(output int ndone, output int lat, output logic [127:0] c_at_done);
        load = 1'b0;
        ndone = 0;
        lat = -1;
        c_at_done = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done_v === 1'b1) begin
                ndone++;
                if (lat < 0) begin
                    lat = k;
                    c_at_done = coeffs_v;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wait_clks(3);
        reset_n = 1'b1;
        wait_clks(2);
        checks++; if (coeffs_v !== 128'h0) begin failures++; $display("FAIL reset_coeffs got=%h exp=%h", coeffs_v, 128'h0); end
        checks++; if (sdo_a !== 1'b0) begin failures++; $display("FAIL reset_sdo got=%b exp=0", sdo_a); end
        checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_a); end
        checks++; if (ferr_a !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", ferr_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
        checks++; if (coeffs_b !== 96'h0) begin failures++; $display("FAIL reset_wide_coeffs got=%h exp=0", coeffs_b); end
        $display("test_reset: done");
    endtask

    task automatic test_first_frame();
        logic [127:0] data, rd, c, exp;
        int nd, lat;
        data = 128'h12345678;
        exp_coef_q.push_back(data);
        start_frame();
        send_bits(32, data, 32, rd);
        end_frame(nd, lat, c);
        exp = exp_coef_q.pop_front();
        checks++; if (nd !== 1) begin failures++; $display("FAIL first_done_count got=%0d exp=1", nd); end
        checks++; if (c !== exp) begin failures++; $display("FAIL first_commit got=%h exp=%h", c, exp); end
        checks++; if (lat !== S + 2) begin failures++; $display("FAIL first_latency got=%0d exp=%0d", lat, S + 2); end
        checks++; if (ferr_v !== 1'b0) begin failures++; $display("FAIL first_frame_err got=%b exp=0", ferr_v); end
        model_coef = data;
        model_sdo = data[31];
        $display("test_first_frame: frame=%h coeffs=%h done_count=%0d", data[31:0], coeffs_v[31:0], nd);
    endtask

    task automatic test_readback();
        logic [127:0] data, rd, c, exp, exp_rd;
        int nd, lat;
        data = 128'hA5A50F0F;
        exp_coef_q.push_back(data);
        exp_rd_q.push_back(model_coef);
        start_frame();
        send_bits(32, data, 32, rd);
        end_frame(nd, lat, c);
        exp = exp_coef_q.pop_front();
        exp_rd = exp_rd_q.pop_front();
        checks++; if (rd[31:0] !== exp_rd[31:0]) begin failures++; $display("FAIL readback_sdo got=%h exp=%h", rd[31:0], exp_rd[31:0]); end
        checks++; if (c !== exp) begin failures++; $display("FAIL readback_commit got=%h exp=%h", c, exp); end
        checks++; if (nd !== 1) begin failures++; $display("FAIL readback_done_count got=%0d exp=1", nd); end
        model_coef = data;
        model_sdo = data[31];
        $display("test_readback: sdo_word=%h coeffs=%h", rd[31:0], coeffs_v[31:0]);
    endtask

    task automatic test_frame_length();
        logic [127:0] rd, c, exp, exp_rd, data;
        int nd, lat;
        int lens[2];
        lens[0] = 31;
        lens[1] = 33;
        foreach (lens[j]) begin
            start_frame();
            send_bits(lens[j], 128'h0BADF00D, 32, rd);
            end_frame(nd, lat, c);
            checks++; if (nd !== 0) begin failures++; $display("FAIL bad_len_%0d_done got=%0d exp=0", lens[j], nd); end
            checks++; if (ferr_v !== 1'b1) begin failures++; $display("FAIL bad_len_%0d_frame_err got=%b exp=1", lens[j], ferr_v); end
            checks++; if (coeffs_v !== model_coef) begin failures++; $display("FAIL bad_len_%0d_coeffs got=%h exp=%h", lens[j], coeffs_v, model_coef); end
            $display("test_frame_length: bits=%0d frame_err=%b done_count=%0d", lens[j], ferr_v, nd);
        end
        data = 128'h5A5AC3C3;
        exp_coef_q.push_back(data);
        exp_rd_q.push_back(model_coef);
        start_frame();
        send_bits(32, data, 32, rd);
        end_frame(nd, lat, c);
        exp = exp_coef_q.pop_front();
        exp_rd = exp_rd_q.pop_front();
        checks++; if (c !== exp) begin failures++; $display("FAIL recover_commit got=%h exp=%h", c, exp); end
        checks++; if (ferr_v !== 1'b0) begin failures++; $display("FAIL recover_frame_err got=%b exp=0", ferr_v); end
        checks++; if (rd[31:0] !== exp_rd[31:0]) begin failures++; $display("FAIL recover_sdo got=%h exp=%h", rd[31:0], exp_rd[31:0]); end
        model_coef = data;
        model_sdo = data[31];
        $display("test_frame_length: recovery coeffs=%h frame_err=%b", coeffs_v[31:0], ferr_v);
    endtask

    task automatic test_reset_mid_frame();
        logic [127:0] rd, c, exp, exp_rd, data;
        int nd, lat;
        start_frame();
        send_bits(16, 128'hFFFF0000, 32, rd);
        reset_n = 1'b0;
        load = 1'b0;
        wait_clks(2);
        checks++; if (coeffs_v !== 128'h0) begin failures++; $display("FAIL midreset_coeffs got=%h exp=0", coeffs_v); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", busy_a); end
        checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL midreset_done got=%b exp=0", done_a); end
        reset_n = 1'b1;
        wait_clks(3);
        model_coef = '0;
        data = 128'hCAFEF00D;
        exp_coef_q.push_back(data);
        exp_rd_q.push_back(model_coef);
        start_frame();
        send_bits(32, data, 32, rd);
        end_frame(nd, lat, c);
        exp = exp_coef_q.pop_front();
        exp_rd = exp_rd_q.pop_front();
        checks++; if (c !== exp) begin failures++; $display("FAIL post_reset_commit got=%h exp=%h", c, exp); end
        checks++; if (rd[31:0] !== exp_rd[31:0]) begin failures++; $display("FAIL post_reset_sdo got=%h exp=%h", rd[31:0], exp_rd[31:0]); end
        model_coef = data;
        model_sdo = data[31];
        $display("test_reset_mid_frame: coeffs=%h done_count=%0d", coeffs_v[31:0], nd);
    endtask

    task automatic test_wide_bank();
        logic [127:0] rd, c, exp, exp_rd, data;
        int nd, lat;
        sel = 1'b1;
        wait_clks(4);
        data = {32'b0, $urandom, $urandom, $urandom};
        exp_coef_q.push_back(data);
        exp_rd_q.push_back(128'h0);
        start_frame();
        send_bits(96, data, 96, rd);
        end_frame(nd, lat, c);
        exp = exp_coef_q.pop_front();
        exp_rd = exp_rd_q.pop_front();
        checks++; if (c !== exp) begin failures++; $display("FAIL wide_commit got=%h exp=%h", c, exp); end
        checks++; if (lat !== S + 2) begin failures++; $display("FAIL wide_latency got=%0d exp=%0d", lat, S + 2); end
        checks++; if (nd !== 1) begin failures++; $display("FAIL wide_done_count got=%0d exp=1", nd); end
        checks++; if (rd[95:0] !== exp_rd[95:0]) begin failures++; $display("FAIL wide_sdo got=%h exp=%h", rd[95:0], exp_rd[95:0]); end
        checks++; if (coeffs_a !== model_coef[31:0]) begin failures++; $display("FAIL wide_isolation got=%h exp=%h", coeffs_a, model_coef[31:0]); end
        $display("test_wide_bank: frame=%h coeffs=%h latency=%0d", data[95:0], coeffs_b, lat);
        sel = 1'b0;
        wait_clks(4);
    endtask

    task automatic test_idle_sck();
        int nd;
        nd = 0;
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sdi = $urandom_range(0, 1);
            sck = 1'b1;
            for (int k = 0; k < 6; k++) begin @(negedge clk); if (done_a === 1'b1) nd++; end
            sck = 1'b0;
            for (int k = 0; k < 6; k++) begin @(negedge clk); if (done_a === 1'b1) nd++; end
        end
        checks++; if (coeffs_a !== model_coef[31:0]) begin failures++; $display("FAIL idle_coeffs got=%h exp=%h", coeffs_a, model_coef[31:0]); end
        checks++; if (sdo_a !== model_sdo) begin failures++; $display("FAIL idle_sdo got=%b exp=%b", sdo_a, model_sdo); end
        checks++; if (nd !== 0) begin failures++; $display("FAIL idle_done got=%0d exp=0", nd); end
        checks++; if (ferr_a !== 1'b0) begin failures++; $display("FAIL idle_frame_err got=%b exp=0", ferr_a); end
        $display("test_idle_sck: coeffs=%h sdo=%b done_count=%0d", coeffs_a, sdo_a, nd);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_frame();
        test_readback();
        test_frame_length();
        test_reset_mid_frame();
        test_wide_bank();
        test_idle_sck();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
